// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bus bundle: IM read port, decoder handshake, redirect and halt status
interface fetch_unit_if #(
   parameter int WORD_SIZE  = 19,
   parameter int ADDR_WIDTH = 10
);

   // Instruction memory read port (ctrl + addr bus, registered read data back)
   logic                  RD_EN_IM;
   logic [ADDR_WIDTH-1:0] im_address;
   logic [WORD_SIZE-1:0]  im_instruction;

   // Instruction register handshake towards the decoder
   logic [WORD_SIZE-1:0]  ir_out;
   logic [ADDR_WIDTH-1:0] ir_pc;
   logic                  ir_valid;
   logic                  ir_ready;

   // Branch redirect from execute and sticky halt status
   logic                  redirect_valid;
   logic [ADDR_WIDTH-1:0] redirect_pc;
   logic                  halted;

   // Fetch unit side
   modport master (
      output RD_EN_IM,
      output im_address,
      input  im_instruction,
      output ir_out,
      output ir_pc,
      output ir_valid,
      input  ir_ready,
      input  redirect_valid,
      input  redirect_pc,
      output halted
   );

   // Memory / decoder / branch unit side
   modport slave (
      input  RD_EN_IM,
      input  im_address,
      output im_instruction,
      input  ir_out,
      input  ir_pc,
      input  ir_valid,
      output ir_ready,
      output redirect_valid,
      output redirect_pc,
      input  halted
   );

endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter and instruction fetch stage for the 19-bit CPU
module fetch_unit #(
   parameter int                    WORD_SIZE   = 19,
   parameter int                    ADDR_WIDTH  = 10,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
   parameter logic [4:0]            HALT_OPCODE = 5'h1F
) (
   input logic          CLK,
   input logic          RESET,
   fetch_unit_if.master bus
);

   // One fetch takes three phases: request, capture the registered IM data, present.
   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LATCH,
      S_DELIVER,
      S_HALTED
   } state_t;

   state_t                state_q,      state_d;
   logic [ADDR_WIDTH-1:0] pc_q,         pc_d;
   logic                  rd_en_im_q,   rd_en_im_d;
   logic [ADDR_WIDTH-1:0] im_address_q, im_address_d;
   logic [WORD_SIZE-1:0]  ir_out_q,     ir_out_d;
   logic [ADDR_WIDTH-1:0] ir_pc_q,      ir_pc_d;
   logic                  ir_valid_q,   ir_valid_d;
   logic                  halted_q,     halted_d;

   logic                  handshake;
   logic                  is_halt_word;
   logic                  take_redirect;

   assign handshake     = ir_valid_q && bus.ir_ready;
   assign is_halt_word  = (ir_out_q[WORD_SIZE-1 -: 5] == HALT_OPCODE);
   // Once halted only reset can restart fetch, so redirects are dropped there.
   assign take_redirect = bus.redirect_valid && (state_q != S_HALTED);

   // Next-state, next-PC and next-output computation; outputs follow the next state so every port is a flop.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ir_out_d     = ir_out_q;
      ir_pc_d      = ir_pc_q;
      halted_d     = halted_q;
      rd_en_im_d   = 1'b0;
      im_address_d = im_address_q;
      ir_valid_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
         end
         S_FETCH: begin
            state_d = S_LATCH;
         end
         S_LATCH: begin
            // IM data requested during FETCH is only trustworthy in this cycle.
            ir_out_d = bus.im_instruction;
            ir_pc_d  = pc_q;
            pc_d     = pc_q + ADDR_WIDTH'(1);
            state_d  = S_DELIVER;
         end
         S_DELIVER: begin
            if (handshake) begin
               if (is_halt_word) begin
                  state_d  = S_HALTED;
                  halted_d = 1'b1;
               end else begin
                  state_d = S_FETCH;
               end
            end
         end
         S_HALTED: begin
            state_d = S_HALTED;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A taken branch overrides everything above: the word in flight is dropped,
      // a HALT being consumed this cycle is cancelled, and fetch restarts at the target.
      if (take_redirect) begin
         state_d  = S_FETCH;
         pc_d     = bus.redirect_pc;
         ir_out_d = ir_out_q;
         ir_pc_d  = ir_pc_q;
         halted_d = halted_q;
      end

      if (state_d == S_FETCH) begin
         rd_en_im_d   = 1'b1;
         im_address_d = pc_d;
      end
      ir_valid_d = (state_d == S_DELIVER);
   end

   // State and output registers; reset wins over redirect, handshake and halt.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q      <= S_IDLE;
         pc_q         <= RESET_PC;
         rd_en_im_q   <= 1'b0;
         im_address_q <= RESET_PC;
         ir_out_q     <= '0;
         ir_pc_q      <= '0;
         ir_valid_q   <= 1'b0;
         halted_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         rd_en_im_q   <= rd_en_im_d;
         im_address_q <= im_address_d;
         ir_out_q     <= ir_out_d;
         ir_pc_q      <= ir_pc_d;
         ir_valid_q   <= ir_valid_d;
         halted_q     <= halted_d;
      end
   end

   assign bus.RD_EN_IM   = rd_en_im_q;
   assign bus.im_address = im_address_q;
   assign bus.ir_out     = ir_out_q;
   assign bus.ir_pc      = ir_pc_q;
   assign bus.ir_valid   = ir_valid_q;
   assign bus.halted     = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

   localparam int WS = 19;
   localparam int AW = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   logic [WS-1:0] mem [0:(1<<AW)-1];

   fetch_unit_if #(.WORD_SIZE(WS), .ADDR_WIDTH(AW)) bus();

   fetch_unit #(
      .WORD_SIZE(WS),
      .ADDR_WIDTH(AW),
      .RESET_PC('0),
      .HALT_OPCODE(5'h1F)
   ) dut (
      .CLK(clk),
      .RESET(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Registered-read instruction memory; garbage when not enabled so stray captures show up
   always @(posedge clk) begin
      if (bus.RD_EN_IM) bus.im_instruction <= mem[bus.im_address];
      else              bus.im_instruction <= WS'($urandom);
   end

   typedef struct {
      logic [AW-1:0] target;
      logic [WS-1:0] word;
      int            stall;
      logic          exp_halt;
      logic [AW-1:0] exp_next;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.ir_ready = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = '0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_rd_en"},  bus.RD_EN_IM,   0);
      chk({tag, "_addr"},   bus.im_address, 0);
      chk({tag, "_ir_out"}, bus.ir_out,     0);
      chk({tag, "_ir_pc"},  bus.ir_pc,      0);
      chk({tag, "_valid"},  bus.ir_valid,   0);
      chk({tag, "_halted"}, bus.halted,     0);
   endtask

   task automatic wait_valid(input int max_cyc);
      int n = 0;
      while (!bus.ir_valid && n < max_cyc) begin
         step();
         n++;
      end
      if (!bus.ir_valid) chk("wait_valid_timeout", bus.ir_valid, 1);
   endtask

   initial begin
      logic [AW-1:0] exp_pc;
      logic          mh;
      int            halt_cnt;
      int            deliveries;
      logic          rdy;
      logic          rv;
      logic [AW-1:0] rpc;
      logic [WS-1:0] held;

      bus.ir_ready = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = '0;
      for (int i = 0; i < (1<<AW); i++) mem[i] = WS'(i + 1);

      // Reset release and 3-cycle throughput
      do_reset();
      chk_reset_vals("rst");
      bus.ir_ready = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         step();
         chk($sformatf("tp_rd_en_c%0d", c), bus.RD_EN_IM, (c % 3 == 1));
         chk($sformatf("tp_valid_c%0d", c), bus.ir_valid, (c % 3 == 0));
         if (c % 3 == 0) begin
            chk($sformatf("tp_out_c%0d", c), bus.ir_out, c / 3);
            chk($sformatf("tp_pc_c%0d", c),  bus.ir_pc,  c / 3 - 1);
         end
      end

      // Backpressure for 5 cycles
      do_reset();
      wait_valid(10);
      for (int k = 0; k < 5; k++) begin
         chk("bp_valid", bus.ir_valid, 1);
         chk("bp_out",   bus.ir_out,   1);
         chk("bp_pc",    bus.ir_pc,    0);
         chk("bp_rd_en", bus.RD_EN_IM, 0);
         if (k < 4) step();
      end
      bus.ir_ready = 1'b1;
      step();
      chk("bp_refetch_rd_en", bus.RD_EN_IM,   1);
      chk("bp_refetch_addr",  bus.im_address, 1);

      // Redirect to 0x200 during LATCH of address 4
      do_reset();
      bus.ir_ready = 1'b1;
      mem['h200] = 19'h15A5A;
      for (int n = 0; n < 40 && !(bus.RD_EN_IM && bus.im_address == 4); n++) step();
      chk("rl_found_fetch4", bus.im_address, 4);
      step();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 10'h200;
      step();
      bus.redirect_valid = 1'b0;
      chk("rl_rd_en", bus.RD_EN_IM,   1);
      chk("rl_addr",  bus.im_address, 'h200);
      wait_valid(10);
      chk("rl_ir_pc",  bus.ir_pc,  'h200);
      chk("rl_ir_out", bus.ir_out, 19'h15A5A);

      // HALT word at address 3: halts, ignores redirect, cleared by reset
      mem[3] = {5'h1F, 14'h0123};
      do_reset();
      bus.ir_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wait_valid(10);
         chk($sformatf("h_pc%0d", k), bus.ir_pc, k);
         if (k < 3) step();
      end
      chk("h_word", bus.ir_out, {5'h1F, 14'h0123});
      step();
      chk("h_halted", bus.halted,   1);
      chk("h_valid",  bus.ir_valid, 0);
      chk("h_rd_en",  bus.RD_EN_IM, 0);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 10'h010;
      step();
      bus.redirect_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("h_hold_halted", bus.halted,   1);
         chk("h_hold_rd_en",  bus.RD_EN_IM, 0);
         chk("h_hold_valid",  bus.ir_valid, 0);
         step();
      end
      do_reset();
      chk_reset_vals("h_rst");

      // Redirect in the same cycle as the HALT handshake
      mem['h050] = 19'h00050;
      bus.ir_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wait_valid(10);
         if (k < 3) step();
      end
      chk("hr_pc3", bus.ir_pc, 3);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 10'h050;
      step();
      bus.redirect_valid = 1'b0;
      chk("hr_halted", bus.halted,     0);
      chk("hr_rd_en",  bus.RD_EN_IM,   1);
      chk("hr_addr",   bus.im_address, 'h050);
      wait_valid(10);
      chk("hr_ir_pc",  bus.ir_pc,  'h050);
      chk("hr_ir_out", bus.ir_out, 19'h00050);
      chk("hr_halted2", bus.halted, 0);

      // Reset during FETCH drops the in-flight word
      do_reset();
      bus.ir_ready = 1'b1;
      wait_valid(10);
      step();
      chk("rf_fetch1_rd_en", bus.RD_EN_IM,   1);
      chk("rf_fetch1_addr",  bus.im_address, 1);
      rst = 1'b1;
      step();
      chk_reset_vals("rf");
      rst = 1'b0;
      wait_valid(10);
      chk("rf_first_pc",  bus.ir_pc,  0);
      chk("rf_first_out", bus.ir_out, 1);

      // Table: redirect from IDLE to target, stall, then consume
      vecs[0] = '{target: 10'h3FF, word: 19'h12345, stall: 0, exp_halt: 1'b0, exp_next: 10'h000};
      vecs[1] = '{target: 10'h200, word: 19'h0ABCD, stall: 3, exp_halt: 1'b0, exp_next: 10'h201};
      vecs[2] = '{target: 10'h000, word: 19'h7C000, stall: 2, exp_halt: 1'b1, exp_next: 10'h000};
      vecs[3] = '{target: 10'h155, word: 19'h7BFFF, stall: 1, exp_halt: 1'b0, exp_next: 10'h156};
      vecs[4] = '{target: 10'h2AA, word: 19'h00000, stall: 4, exp_halt: 1'b0, exp_next: 10'h2AB};
      for (int i = 0; i < 5; i++) begin
         mem[vecs[i].target] = vecs[i].word;
         do_reset();
         bus.redirect_valid = 1'b1;
         bus.redirect_pc = vecs[i].target;
         step();
         bus.redirect_valid = 1'b0;
         chk($sformatf("tv%0d_rd_en", i), bus.RD_EN_IM,   1);
         chk($sformatf("tv%0d_addr", i),  bus.im_address, vecs[i].target);
         wait_valid(10);
         chk($sformatf("tv%0d_ir_pc", i),  bus.ir_pc,  vecs[i].target);
         chk($sformatf("tv%0d_ir_out", i), bus.ir_out, vecs[i].word);
         held = bus.ir_out;
         for (int s = 0; s < vecs[i].stall; s++) step();
         chk($sformatf("tv%0d_stall_valid", i), bus.ir_valid, 1);
         chk($sformatf("tv%0d_stall_out", i),   bus.ir_out,   held);
         bus.ir_ready = 1'b1;
         step();
         chk($sformatf("tv%0d_halted", i), bus.halted,   vecs[i].exp_halt);
         chk($sformatf("tv%0d_next_rd", i), bus.RD_EN_IM, !vecs[i].exp_halt);
         if (!vecs[i].exp_halt)
            chk($sformatf("tv%0d_next_addr", i), bus.im_address, vecs[i].exp_next);
      end

      // Random stimulus against a transaction-level model
      for (int i = 0; i < (1<<AW); i++) begin
         logic [WS-1:0] w;
         w = WS'($urandom);
         if (w[WS-1 -: 5] == 5'h1F) w[WS-1] = 1'b0;
         if ($urandom_range(0, 31) == 0) w[WS-1 -: 5] = 5'h1F;
         mem[i] = w;
      end
      do_reset();
      exp_pc = '0;
      mh = 1'b0;
      halt_cnt = 0;
      deliveries = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         chk("rnd_halted", bus.halted, mh);
         if (mh) begin
            chk("rnd_halt_valid", bus.ir_valid, 0);
            chk("rnd_halt_rd_en", bus.RD_EN_IM, 0);
            halt_cnt++;
            if (halt_cnt > 3) begin
               rst = 1'b1;
               bus.ir_ready = 1'b0;
               bus.redirect_valid = 1'b0;
               step();
               rst = 1'b0;
               mh = 1'b0;
               exp_pc = '0;
               halt_cnt = 0;
               continue;
            end
         end
         rdy = ($urandom_range(0, 3) != 0);
         rv  = ($urandom_range(0, 9) == 0);
         rpc = AW'($urandom);
         if (bus.ir_valid && rdy) begin
            chk("rnd_ir_pc",  bus.ir_pc,  exp_pc);
            chk("rnd_ir_out", bus.ir_out, mem[exp_pc]);
            deliveries++;
         end
         if (!mh) begin
            if (rv) begin
               exp_pc = rpc;
            end else if (bus.ir_valid && rdy) begin
               if (mem[exp_pc][WS-1 -: 5] == 5'h1F) mh = 1'b1;
               else exp_pc = exp_pc + 1'b1;
            end
         end
         bus.ir_ready = rdy;
         bus.redirect_valid = rv;
         bus.redirect_pc = rpc;
         step();
      end
      chk("rnd_progress", (deliveries > 100), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
